// File: rtl/io_in_fifo.sv
// Show-ahead input FIFO between an external input device and the datapath select stage.
// Optional dropped-write counter compiled in with IO_IN_FIFO_OVF_COUNT_EN.
module io_in_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DIn,
  input  logic             DInValid,
  output logic             DInReady,
  input  logic             RdEn,
  output logic [WIDTH-1:0] DOut,
  output logic             Empty,
  output logic             Full,
  output logic [3:0]       Count,
  output logic [7:0]       OvfCnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [3:0]       count;
  logic             empty;
  logic             full;
  logic             wr_acc;
  logic             rd_acc;
  logic             drop;

  // Flags come only from the registered count, so no input reaches an output.
  always_comb begin
    empty  = (count == 4'd0);
    full   = (count == 4'(DEPTH));
    wr_acc = DInValid && !full;
    rd_acc = RdEn && !empty;
    drop   = DInValid && full;
  end

  always_ff @(posedge CLK) begin
    if (wr_acc && !Reset) begin
      mem[wr_ptr] <= DIn;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IO_IN_FIFO_OVF_COUNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  assign OvfCnt = ovf_cnt;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign OvfCnt      = '0;
`endif

  assign DOut     = empty ? '0 : mem[rd_ptr];
  assign Empty    = empty;
  assign Full     = full;
  assign DInReady = !full;
  assign Count    = count;

endmodule

// File: tb/tb_io_in_fifo.sv
// Directed self-checking bench for io_in_fifo (DEPTH=4, WIDTH=16).
module tb_io_in_fifo;

`ifdef IO_IN_FIFO_OVF_COUNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] DIn;
  logic        DInValid;
  logic        DInReady;
  logic        RdEn;
  logic [15:0] DOut;
  logic        Empty;
  logic        Full;
  logic [3:0]  Count;
  logic [7:0]  OvfCnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  logic [15:0] head;

  io_in_fifo #(.DEPTH(4), .WIDTH(16)) dut (
    .CLK(CLK), .Reset(Reset), .DIn(DIn), .DInValid(DInValid),
    .DInReady(DInReady), .RdEn(RdEn), .DOut(DOut), .Empty(Empty),
    .Full(Full), .Count(Count), .OvfCnt(OvfCnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    DIn = d; DInValid = 1'b1;
    tick();
    DInValid = 1'b0;
  endtask

  task automatic pop();
    RdEn = 1'b1;
    tick();
    RdEn = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; DIn = '0; DInValid = 1'b0; RdEn = 1'b0;
    tick(); tick();
    Reset = 1'b0;

    // reset state
    chk("rst_empty", 16'(Empty), 16'd1);
    chk("rst_full", 16'(Full), 16'd0);
    chk("rst_ready", 16'(DInReady), 16'd1);
    chk("rst_count", 16'(Count), 16'd0);
    chk("rst_dout", DOut, 16'h0000);
    chk("rst_ovf", 16'(OvfCnt), 16'd0);

    // single write, one-cycle visibility
    push(16'h1234);
    chk("w1_dout", DOut, 16'h1234);
    chk("w1_count", 16'(Count), 16'd1);
    chk("w1_empty", 16'(Empty), 16'd0);
    pop();
    chk("p1_empty", 16'(Empty), 16'd1);
    chk("p1_dout", DOut, 16'h0000);

    // pop while empty is a no-op
    pop();
    chk("pe_count", 16'(Count), 16'd0);
    chk("pe_empty", 16'(Empty), 16'd1);

    // fill, overflow, drain
    for (int i = 0; i < 4; i++) push(16'hA001 + 16'(i));
    chk("full_flag", 16'(Full), 16'd1);
    chk("full_ready", 16'(DInReady), 16'd0);
    chk("full_count", 16'(Count), 16'd4);
    push(16'hA005);
    chk("ovf_count", 16'(Count), 16'd4);
    chk("ovf_cnt1", 16'(OvfCnt), OVF_EN ? 16'd1 : 16'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_dout", DOut, 16'hA001 + 16'(i));
      pop();
    end
    chk("drain_empty", 16'(Empty), 16'd1);
    chk("drain_dout0", DOut, 16'h0000);
    chk("drain_count", 16'(Count), 16'd0);

    // full with simultaneous write and pop: pop wins, write dropped
    for (int i = 0; i < 4; i++) push(16'hB001 + 16'(i));
    DIn = 16'hB005; DInValid = 1'b1; RdEn = 1'b1;
    tick();
    DInValid = 1'b0; RdEn = 1'b0;
    chk("fwp_count", 16'(Count), 16'd3);
    chk("fwp_ovf", 16'(OvfCnt), OVF_EN ? 16'd2 : 16'd0);
    for (int i = 1; i < 4; i++) begin
      chk("fwp_dout", DOut, 16'hB001 + 16'(i));
      pop();
    end
    chk("fwp_empty", 16'(Empty), 16'd1);

    // empty with simultaneous write and pop: write taken, pop ignored
    DIn = 16'h00FF; DInValid = 1'b1; RdEn = 1'b1;
    tick();
    DInValid = 1'b0; RdEn = 1'b0;
    chk("ewp_count", 16'(Count), 16'd1);
    chk("ewp_dout", DOut, 16'h00FF);

    // steady-state write/pop pairs across pointer wraps
    push(16'hC001);
    q.push_back(16'h00FF);
    q.push_back(16'hC001);
    for (int i = 0; i < 10; i++) begin
      head = q.pop_front();
      chk("pair_dout", DOut, head);
      q.push_back(16'hD000 + 16'(i));
      DIn = 16'hD000 + 16'(i); DInValid = 1'b1; RdEn = 1'b1;
      tick();
      DInValid = 1'b0; RdEn = 1'b0;
      chk("pair_count", 16'(Count), 16'd2);
    end
    chk("pair_tail0", DOut, 16'hD008);
    pop();
    chk("pair_tail1", DOut, 16'hD009);

    // reset wins over an offered write
    push(16'hE001);
    push(16'hE002);
    chk("pre_rst_count", 16'(Count), 16'd3);
    Reset = 1'b1; DIn = 16'hE003; DInValid = 1'b1;
    tick();
    Reset = 1'b0; DInValid = 1'b0;
    chk("rw_count", 16'(Count), 16'd0);
    chk("rw_empty", 16'(Empty), 16'd1);
    chk("rw_ovf", 16'(OvfCnt), 16'd0);
    chk("rw_dout", DOut, 16'h0000);
    push(16'hF001);
    chk("post_rst_dout", DOut, 16'hF001);
    chk("post_rst_count", 16'(Count), 16'd1);

    // overflow counter saturation
    for (int i = 0; i < 3; i++) push(16'hF002 + 16'(i));
    DIn = 16'hFFFF; DInValid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    DInValid = 1'b0;
    chk("sat_ovf", 16'(OvfCnt), OVF_EN ? 16'h00FF : 16'h0000);
    chk("sat_count", 16'(Count), 16'd4);
    chk("sat_dout", DOut, 16'hF001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_in_fifo.md
IO_IN_FIFO -- requirements
Module: io_in_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 16-bit entries; power of two, 2..8.
REQ-002 SHALL have parameter WIDTH, default 16, data word width; matches the datapath 16-bit select stage fed by DOut.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port DIn  input  WIDTH  word from external input device.
REQ-006 SHALL have port DInValid  input  1  device offers DIn this cycle.
REQ-007 SHALL have port DInReady  output  1  FIFO can accept a word this cycle (= !Full).
REQ-008 SHALL have port RdEn  input  1  processor pops head word (one pulse = one word).
REQ-009 SHALL have port DOut  output  WIDTH  head-of-queue word (show-ahead); drives datapath input-select leg.
REQ-010 SHALL have port Empty  output  1  no words stored.
REQ-011 SHALL have port Full  output  1  DEPTH words stored.
REQ-012 SHALL have port Count  output  4  number of stored words, 0..DEPTH.
REQ-013 SHALL have port OvfCnt  output  8  dropped-write counter (see Configuration).

Function
REQ-014 SHALL accept a write at a rising edge iff DInValid=1 and Full=0 at that edge; word stored at write pointer, write pointer +1 modulo DEPTH.
REQ-015 SHALL perform a pop at a rising edge iff RdEn=1 and Empty=0; read pointer +1 modulo DEPTH.
REQ-016 SHALL treat RdEn while Empty=1 as a no-op: no pointer or Count change, no error flag.
REQ-017 SHALL drop a write offered while Full=1, even if a pop occurs the same edge; stored data unchanged.
REQ-018 SHALL, on simultaneous accepted write and pop, leave Count unchanged and advance both pointers.
REQ-019 SHALL, on write while Empty=1 with RdEn=1, accept the write and ignore the pop; Count becomes 1.
REQ-020 SHALL update Count: +1 write only, -1 pop only, unchanged for both or neither.
REQ-021 SHALL derive Empty=(Count==0), Full=(Count==DEPTH), DInReady=!Full from registered state only; no combinational path from DInValid or RdEn to any output.
REQ-022 SHALL present DOut = entry at read pointer when Empty=0, and 16'h0000 when Empty=1.
REQ-023 SHALL make a word written at edge k visible on DOut after edge k (one-cycle write-to-read latency) when the FIFO was empty.
REQ-024 SHALL make the next word visible on DOut immediately after the popping edge (zero-cycle pop-to-next latency).
REQ-025 SHALL wrap pointers seamlessly; order preserved across any number of wrap-arounds.

Reset
REQ-026 SHALL, when Reset=1 at a rising edge, clear both pointers and Count to 0 and OvfCnt to 0; Empty=1, Full=0, DInReady=1, DOut=16'h0000 thereafter.
REQ-027 SHALL give Reset priority over any simultaneous write or pop; the word offered that edge is discarded.
REQ-028 SHALL NOT require clearing storage array contents on reset.

Configuration
REQ-029 SHALL use macro IO_IN_FIFO_OVF_COUNT_EN to compile in the overflow counter.
REQ-030 SHALL, with IO_IN_FIFO_OVF_COUNT_EN defined, increment OvfCnt by 1 per dropped write (REQ-017), saturating at 8'hFF; cleared only by Reset.
REQ-031 SHALL, without IO_IN_FIFO_OVF_COUNT_EN, drive OvfCnt constant 8'h00 with no counter logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: Reset, then write 16'h1234 one cycle -> next cycle DOut=16'h1234, Count=1, Empty=0.
REQ-033 SHALL cover: write 16'hA001..16'hA004 (DEPTH=4) -> Full=1, DInReady=0; fifth write 16'hA005 dropped; pops return A001..A004 in order, then Empty=1, DOut=16'h0000.
REQ-034 SHALL cover: FIFO full, DInValid=1 and RdEn=1 same edge -> pop occurs, write dropped, Count=3, OvfCnt=1 (macro defined) / 0 (undefined).
REQ-035 SHALL cover: Empty, DInValid=1 with 16'h00FF and RdEn=1 same edge -> Count=1, DOut=16'h00FF.
REQ-036 SHALL cover: 10 write/pop pairs with Count held at 2 (pointer wrap) -> outputs in exact write order, Count stays 2.
REQ-037 SHALL cover: Reset asserted with Count=3 and DInValid=1 -> next cycle Count=0, Empty=1, OvfCnt=0, offered word absent.
